// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiter and its helpers.
//   arb_state_e        : arbiter FSM encoding (ST_IDLE / ST_BUSY)
//   BUS_*_W            : system bus field widths
//   ERR_RDATA_DEFAULT  : read data returned to a master whose transaction timed out
package bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  localparam logic [BUS_DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_qos_arbiter_if.sv
// Bundles the master request ports and the shared-bus side of the arbiter.
//   m_addr/m_wdata/m_wstrb/m_write/m_enable/m_lock : packed per-master requests
//   m_rdata/m_ready/m_err                          : per-master responses
//   bus_addr/bus_wdata/bus_wstrb/bus_write/bus_enable : muxed owner request
//   bus_rdata/bus_ready                            : slave response
// Modports:
//   slave  : arbiter view (receives requests, drives the bus)
//   master : environment view (requestors plus bus slave)
interface bus_qos_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  import bus_pkg::*;

  logic [NUM_MASTERS*BUS_ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*BUS_STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS-1:0]            m_enable;
  logic [NUM_MASTERS-1:0]            m_lock;
  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_rdata;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic [NUM_MASTERS-1:0]            m_err;

  logic [BUS_ADDR_W-1:0]             bus_addr;
  logic [BUS_DATA_W-1:0]             bus_wdata;
  logic [BUS_STRB_W-1:0]             bus_wstrb;
  logic                              bus_write;
  logic                              bus_enable;
  logic [BUS_DATA_W-1:0]             bus_rdata;
  logic                              bus_ready;

  modport slave (
    input  m_addr, m_wdata, m_wstrb, m_write, m_enable, m_lock,
    input  bus_rdata, bus_ready,
    output m_rdata, m_ready, m_err,
    output bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable
  );

  modport master (
    output m_addr, m_wdata, m_wstrb, m_write, m_enable, m_lock,
    output bus_rdata, bus_ready,
    input  m_rdata, m_ready, m_err,
    input  bus_addr, bus_wdata, bus_wstrb, bus_write, bus_enable
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Returns the first set bit of req scanning upward from ptr, wrapping to 0.
//   req    : request vector
//   ptr    : index with highest priority
//   onehot : one-hot winner (0 when no request)
//   idx    : winner index (0 when no request)
//   any    : at least one request set
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;
  logic             hi_any;
  logic             lo_any;

  // Two descending scans: the last hit is the lowest index. idx_hi only
  // considers bits at or above ptr; if none exist, wrap to the lowest set bit.
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDX_W'(i);
        lo_any = 1'b1;
        if (IDX_W'(i) >= ptr) begin
          idx_hi = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any    = lo_any;
    idx    = hi_any ? idx_hi : idx_lo;
    onehot = '0;
    if (lo_any) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_qos_arbiter.sv
// N-master round-robin arbiter for the shared system bus with optional
// lock for back-to-back transactions and a per-transaction watchdog that
// completes a hung transaction with an error response.
//   clk, rst      : clock, synchronous active-high reset
//   bif (slave)   : master request/response ports and shared-bus ports
//   grant         : one-hot registered owner, 0 when idle
//   timeout_pulse : one-cycle pulse in the cycle the watchdog expires
//   timeout_id    : owner index at the most recent timeout
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no owner, bus outputs 0; pick next owner from rr_ptr
// ST_BUSY | owner_q drives the bus until completion, abort or timeout
module bus_qos_arbiter
  import bus_pkg::*;
#(
  parameter int                    NUM_MASTERS    = 4,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter int                    MAX_LOCK       = 4,
  parameter logic [BUS_DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int                    IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  bus_qos_arbiter_if.slave       bif,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout_pulse,
  output logic [IDX_W-1:0]       timeout_id
);

  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       timeout_id_q, timeout_id_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   busy;
  logic                   own_en;
  logic                   own_lock;
  logic                   complete;
  logic                   expire;
  logic [IDX_W-1:0]       owner_inc;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bif.m_enable),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // bus_ready beats the watchdog when both land in the same cycle.
  always_comb begin
    busy      = (state_q == ST_BUSY);
    own_en    = bif.m_enable[owner_q];
    own_lock  = bif.m_lock[owner_q];
    complete  = busy & own_en & bif.bus_ready;
    expire    = busy & own_en & ~bif.bus_ready & (wd_cnt_q == WD_LAST);
    owner_inc = (owner_q == IDX_MAX) ? '0 : owner_q + IDX_W'(1);
  end

  // Owner mux and response steering; everything is 0 outside BUSY.
  always_comb begin
    bif.bus_addr   = '0;
    bif.bus_wdata  = '0;
    bif.bus_wstrb  = '0;
    bif.bus_write  = 1'b0;
    bif.bus_enable = 1'b0;
    bif.m_rdata    = '0;
    bif.m_ready    = '0;
    bif.m_err      = '0;
    timeout_pulse  = expire;
    if (busy) begin
      bif.bus_addr   = bif.m_addr[owner_q*BUS_ADDR_W +: BUS_ADDR_W];
      bif.bus_wdata  = bif.m_wdata[owner_q*BUS_DATA_W +: BUS_DATA_W];
      bif.bus_wstrb  = bif.m_wstrb[owner_q*BUS_STRB_W +: BUS_STRB_W];
      bif.bus_write  = bif.m_write[owner_q];
      // Withdraw the request from the slave in the cycle we give up on it.
      bif.bus_enable = own_en & ~expire;
      bif.m_rdata[owner_q*BUS_DATA_W +: BUS_DATA_W] = expire ? ERR_RDATA : bif.bus_rdata;
      bif.m_ready[owner_q] = complete | expire;
      bif.m_err[owner_q]   = expire;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    timeout_id_d = timeout_id_q;
    lock_cnt_d   = lock_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_BUSY;
          grant_d  = pick_onehot;
          owner_d  = pick_idx;
          wd_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (!own_en) begin
          // Abort: owner withdrew; any bus_ready this cycle is ignored.
          state_d    = ST_IDLE;
          grant_d    = '0;
          rr_ptr_d   = owner_inc;
          lock_cnt_d = '0;
          wd_cnt_d   = '0;
        end else if (bif.bus_ready) begin
          rr_ptr_d = owner_inc;
          wd_cnt_d = '0;
          if (own_lock && (lock_cnt_q < LOCK_LAST)) begin
            // Locked back-to-back: keep the grant, no idle bubble.
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end else begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            lock_cnt_d = '0;
          end
        end else if (expire) begin
          // Forced release regardless of lock.
          state_d      = ST_IDLE;
          grant_d      = '0;
          rr_ptr_d     = owner_inc;
          lock_cnt_d   = '0;
          wd_cnt_d     = '0;
          timeout_id_d = owner_q;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      timeout_id_q <= '0;
      lock_cnt_q   <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      timeout_id_q <= timeout_id_d;
      lock_cnt_q   <= lock_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign timeout_id = timeout_id_q;

endmodule
